speed_conv_ctrl: RTL
====================

Name: speed_conv_ctrl

Overview:
- Owns the playback-rate divider count of the audio path.
- Applies user speed-up, speed-down and speed-reset requests to the 27 MHz-domain count, saturating at fixed limits.
- Sequences a multi-cycle multiply/restoring-divide that converts the count to its 50 MHz equivalent, count × NUM / DEN, with integer truncation.
- Publishes both counts to the audio clock divider and the HEX display, with a completion pulse.

Parameters:
- DEFAULT_COUNT, 614: count on reset, about a 22 kHz sample toggle at 27 MHz.
- STEP, 16: count change per speed request.
- MIN_COUNT, 64: lower saturation limit (fastest speed).
- MAX_COUNT, 65535: upper saturation limit (slowest speed).
- NUM, 50: conversion numerator (MHz).
- DEN, 27: conversion denominator (MHz); must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- speed_up  in  1  1-cycle pulse; count -= STEP (faster playback)
- speed_down  in  1  1-cycle pulse; count += STEP (slower playback)
- speed_reset  in  1  1-cycle pulse; count = DEFAULT_COUNT
- count_on_27MHz  out  32  current divider count in the 27 MHz domain
- count_on_50MHz  out  32  converted count, floor(count_on_27MHz × NUM / DEN)
- busy  out  1  conversion in progress
- conv_done  out  1  1-cycle pulse when count_on_50MHz is updated

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on posedge clk, and overrides everything, including an in-flight conversion and any pending request.
- Reset values:
  - count_on_27MHz = DEFAULT_COUNT.
  - count_on_50MHz = DEFAULT_COUNT × NUM / DEN, a compile-time constant (1137 at defaults).
  - busy = 0, conv_done = 0, pending slot empty, state IDLE.
- Request decode, applied identically to live inputs and to the pending slot:
  - speed_reset wins over all.
  - speed_up and speed_down together with no speed_reset: no-op, nothing is queued and no conversion runs.
  - speed_up alone: new = max(count − STEP, MIN_COUNT).
  - speed_down alone: new = min(count + STEP, MAX_COUNT).
  - Subtraction must not underflow; compare before subtracting.
- A request that leaves the count unchanged (already saturated) still runs a conversion and pulses conv_done.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on a valid request (pending slot first, else live inputs), register the new count into count_on_27MHz at the next edge, clear pending, and go to MUL.
  - MUL, 1 cycle: prod[39:0] = count_on_27MHz × NUM; load the divider (quotient = 0, remainder = 0, bit index = 39); go to DIV.
  - DIV, exactly 40 cycles: one restoring-divide step per cycle, MSB first.
    - rem = {rem, prod[i]}.
    - If rem ≥ DEN: rem −= DEN and q[i] = 1.
    - After bit 0, go to DONE.
  - DONE, 1 cycle:
    - count_on_50MHz = q[31:0], or 32'hFFFF_FFFF if q[39:32] ≠ 0.
    - conv_done = 1 for this cycle only.
    - Next state is IDLE.
- busy is high in MUL, DIV and DONE, and low in IDLE.
- Latency:
  - A request sampled in IDLE at edge E0 changes count_on_27MHz at E0+1.
  - conv_done is high in the cycle after edge E0+42, and count_on_50MHz is valid from that same edge.
- Requests while busy=1 (MUL/DIV/DONE):
  - The decoded request is stored in a one-deep pending slot; a later request overwrites it.
  - Pending is serviced in IDLE, one cycle after DONE.
  - In that IDLE cycle pending takes precedence and a simultaneous live request is dropped.
  - Pending stores the request type, not a count; it is decoded against count_on_27MHz at the moment it is serviced.
- count_on_27MHz never changes while busy=1. count_on_50MHz changes only in DONE or on reset.

Test Plan:
- Reset, then idle for 100 cycles -> count_on_27MHz=614, count_on_50MHz=1137, busy=0, conv_done never asserted.
- speed_up pulse -> count_on_27MHz=598 one cycle later; conv_done 42 cycles after the request edge with count_on_50MHz=1107. A following speed_down -> 614 and 1137.
- speed_down from 614 -> 630 and 1166. speed_up and speed_down in the same cycle -> no change, busy stays 0.
- 40 speed_up pulses, each after conv_done -> count saturates at 64 and count_on_50MHz=118; one more speed_up -> count stays 64 and conv_done still pulses. From MAX_COUNT, speed_down -> stays 65535, count_on_50MHz=121361.
- speed_down mid-DIV, then speed_up mid-DIV -> the first conversion completes, then a second one starts with the pending speed_up only (614 -> 598 -> 1107).
- rst asserted mid-DIV after a speed_up -> next cycle shows 614/1137, busy=0, no conv_done pulse, pending cleared.

Source files
------------

// File: rtl/speed_conv_ctrl.sv
// Playback-rate divider count owner for the audio path.
// Converts the 27 MHz count to its 50 MHz equivalent by multiply/restoring-divide.
module speed_conv_ctrl #(
    parameter int unsigned DEFAULT_COUNT = 614,
    parameter int unsigned STEP          = 16,
    parameter int unsigned MIN_COUNT     = 64,
    parameter int unsigned MAX_COUNT     = 65535,
    parameter int unsigned NUM           = 50,
    parameter int unsigned DEN           = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        speed_up,
    input  logic        speed_down,
    input  logic        speed_reset,
    output logic [31:0] count_on_27MHz,
    output logic [31:0] count_on_50MHz,
    output logic        busy,
    output logic        conv_done
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_RST, REQ_UP, REQ_DOWN} req_t;

    localparam logic [63:0] RST50_FULL =
        64'(DEFAULT_COUNT) * 64'(NUM) / 64'(DEN);
    localparam logic [31:0] RST50 =
        (RST50_FULL > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF
                                               : RST50_FULL[31:0];
    localparam logic [31:0] DEF_C   = 32'(DEFAULT_COUNT);
    localparam logic [31:0] MIN_C   = 32'(MIN_COUNT);
    localparam logic [31:0] MAX_C   = 32'(MAX_COUNT);
    localparam logic [31:0] STEP_C  = 32'(STEP);
    localparam logic [31:0] UP_LIM  = 32'(MIN_COUNT + STEP);
    localparam logic [31:0] DN_LIM  = 32'(MAX_COUNT - STEP);
    localparam logic [32:0] DEN_C   = 33'(DEN);

    state_t      state_q, state_d;
    req_t        pend_q, pend_d;
    req_t        live_req, sel_req;
    logic [31:0] count_q, count_d;
    logic [31:0] out_q, out_d;
    logic [39:0] prod_q, prod_d;
    logic [39:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [32:0] rem_sh;
    logic [5:0]  idx_q, idx_d;

    function automatic req_t decode(input logic r, input logic u,
                                    input logic d);
        if (r)             return REQ_RST;
        else if (u && !d)  return REQ_UP;
        else if (d && !u)  return REQ_DOWN;
        else               return REQ_NONE;
    endfunction

    // Saturating update; compare first so the subtraction cannot wrap.
    function automatic logic [31:0] apply(input req_t rq,
                                          input logic [31:0] c);
        unique case (rq)
            REQ_RST:  return DEF_C;
            REQ_UP:   return (c >= UP_LIM) ? c - STEP_C : MIN_C;
            REQ_DOWN: return (c > DN_LIM) ? MAX_C : c + STEP_C;
            default:  return c;
        endcase
    endfunction

    // Next-state, datapath and handshake outputs.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        count_d  = count_q;
        out_d    = out_q;
        prod_d   = prod_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        rem_sh   = '0;
        live_req = decode(speed_reset, speed_up, speed_down);
        sel_req  = REQ_NONE;
        unique case (state_q)
            IDLE: begin
                sel_req = (pend_q != REQ_NONE) ? pend_q : live_req;
                if (sel_req != REQ_NONE) begin
                    count_d = apply(sel_req, count_q);
                    pend_d  = REQ_NONE;
                    state_d = MUL;
                end
            end
            MUL: begin
                prod_d  = 40'(count_q) * 40'(NUM);
                quo_d   = '0;
                rem_d   = '0;
                idx_d   = 6'd39;
                state_d = DIV;
            end
            DIV: begin
                rem_sh = {rem_q, prod_q[idx_q]};
                if (rem_sh >= DEN_C) begin
                    rem_d        = 32'(rem_sh - DEN_C);
                    quo_d[idx_q] = 1'b1;
                end else begin
                    rem_d = rem_sh[31:0];
                end
                if (idx_q == 6'd0) begin
                    out_d   = (quo_d[39:32] != 8'd0) ? 32'hFFFF_FFFF
                                                     : quo_d[31:0];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 6'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && live_req != REQ_NONE) begin
            pend_d = live_req;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= REQ_NONE;
            count_q <= DEF_C;
            out_q   <= RST50;
            prod_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            out_q   <= out_d;
            prod_q  <= prod_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
        end
    end

    assign count_on_27MHz = count_q;
    assign count_on_50MHz = out_q;
    assign busy           = (state_q != IDLE);
    assign conv_done      = (state_q == DONE);

endmodule
